ai_cmp_sched: RTL and testbench
===============================

AI_CMP_SCHED -- requirements
Module: ai_cmp_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 500000: idle cycles without char_rdy before a session ends.
REQ-002 The block SHALL have parameter FRAME_SHIFT, default 9: log2 of characters expected per length unit.
REQ-003 The block SHALL have clk  in  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have req  in  2  level request per requester (0, 1).
REQ-006 The block SHALL have req_len0 / req_len1  in  16 each  session length from requester 0 / 1.
REQ-007 The block SHALL have char_rdy  in  1  one-cycle pulse per recognised character from the comparer.
REQ-008 The block SHALL have abort  in  1  terminates the running session.
REQ-009 The block SHALL have gnt  out  2  one-hot grant, held for the whole session.
REQ-010 The block SHALL have init  out  1  one-cycle session-start pulse to the comparer.
REQ-011 The block SHALL have len_out  out  16  latched session length, valid while gnt != 0.
REQ-012 The block SHALL have busy  out  1  high in any state other than IDLE.
REQ-013 The block SHALL have done  out  1  one-cycle end-of-session pulse.
REQ-014 The block SHALL have done_err  out  1  result error flag, valid with done.
REQ-015 The block SHALL have done_id  out  1  index of the requester that owned the session, valid with done.

Function
REQ-016 The FSM SHALL have states IDLE, INIT, RUN and REPORT, with all outputs decoded from registered state/regs.
REQ-017 In IDLE with req != 0, the block SHALL choose a winner round-robin (the requester not granted last wins when both request), latch its length and go to INIT on the next edge.
REQ-018 In INIT (exactly one cycle), init=1, gnt=winner, the character counter and timer SHALL clear, and the next state SHALL be RUN.
REQ-019 Expected count SHALL be (len_out-1)<<FRAME_SHIFT in 25 bits; len_out=0 SHALL give expected=0 (no underflow).
REQ-020 In RUN, each char_rdy SHALL increment the 25-bit counter (saturating at 2^25-1) and zero the timer; otherwise the timer increments.
REQ-021 RUN SHALL exit to REPORT on the first of: counter==expected (success), timer==TIMEOUT-1 (timeout), or abort.
REQ-022 When char_rdy and timer==TIMEOUT-1 occur in the same cycle, char_rdy SHALL win (counter increments, timer zeroed, no exit).
REQ-023 When abort coincides with any other exit condition, abort SHALL win.
REQ-024 In REPORT (exactly one cycle), done=1 and done_id=owner; done_err=1 if abort, or if counter<expected, else 0; gnt stays asserted; the next state SHALL be IDLE with the round-robin pointer updated to the owner.
REQ-025 gnt SHALL deassert in IDLE; a requester that still holds req SHALL be eligible again, subject to round-robin.
REQ-026 char_rdy outside RUN SHALL be ignored; req changes during a session SHALL not affect gnt or len_out.
REQ-027 Latency: req high in IDLE at cycle N -> init and gnt at N+1 -> RUN from N+2.

Reset
REQ-028 rst SHALL force state IDLE, gnt=0, init=0, done=0, done_err=0, done_id=0, busy=0, len_out=0, counter=0, timer=0 and round-robin pointer such that requester 0 wins the first tie.
REQ-029 rst mid-session SHALL abandon the session without a done pulse.

Structure
REQ-030 Package ai_cmp_pkg SHALL hold the state enum, CNT_W=25, FRAME_SHIFT default and TIMEOUT default.
REQ-031 Timer width SHALL be $clog2(TIMEOUT).
REQ-032 The two-way round-robin arbiter SHALL be the sub-module ai_rr_arb2 (req, pointer -> one-hot winner).

Verification (TIMEOUT=100 in sim)
REQ-033 Case 1: req=01, len0=2, 512 char_rdy pulses -> init at N+1, done with done_err=0 one cycle after the 512th pulse, done_id=0.
REQ-034 Case 2: req=10, len1=3, 600 pulses then silence -> done 100 cycles after the last pulse, done_err=1, done_id=1.
REQ-035 Case 3: req=11 held over 3 sessions -> grants in the order 0,1,0.
REQ-036 Case 4: len0=0 -> done in the first RUN cycle, done_err=0.
REQ-037 Case 5: abort in RUN on the same cycle as the 1024th pulse (len=3) -> done_err=1.
REQ-038 Case 6: rst during RUN -> all outputs 0 next cycle, no done; char_rdy at timer=99 -> no exit.

Source files
------------

// File: rtl/ai_cmp_pkg.sv
// ai_cmp_pkg: shared state enum, widths, defaults and expected-count helper for the compare scheduler
package ai_cmp_pkg;
  typedef enum logic [1:0] {IDLE, INIT, RUN, REPORT} state_t;
  localparam int CNT_W = 25;
  localparam int FRAME_SHIFT_DEF = 9;
  localparam int TIMEOUT_DEF = 500000;
  function automatic logic [CNT_W-1:0] exp_cnt(input logic [15:0] len, input int shift);
    exp_cnt = (len == 16'd0) ? '0 : CNT_W'(len - 16'd1) << shift;
  endfunction
endpackage

// File: rtl/ai_rr_arb2.sv
// ai_rr_arb2: two-way round-robin arbiter; req/ptr (last owner) in, one-hot win out
module ai_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);
  always_comb win = (&req) ? (ptr ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/ai_cmp_sched.sv
// ai_cmp_sched: arbitrates two requesters into compare sessions (clk/rst, req/len in, char_rdy/abort in; gnt/init/len_out/busy/done* out)
module ai_cmp_sched
  import ai_cmp_pkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int FRAME_SHIFT = FRAME_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] req_len0,
  input  logic [15:0] req_len1,
  input  logic        char_rdy,
  input  logic        abort,
  output logic [1:0]  gnt,
  output logic        init,
  output logic [15:0] len_out,
  output logic        busy,
  output logic        done,
  output logic        done_err,
  output logic        done_id
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d, win;
  logic             init_q, init_d, done_q, done_d, err_q, err_d, id_q, id_d, ptr_q, ptr_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, exp_c;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             stop;

  ai_rr_arb2 u_arb (.req(req), .ptr(ptr_q), .win(win));

  // success is judged on the post-increment count so done follows the last pulse by one cycle
  always_comb begin
    exp_c   = exp_cnt(len_q, FRAME_SHIFT);
    cnt_inc = (char_rdy && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    stop    = abort || cnt_inc == exp_c || (!char_rdy && tmr_q == T_LAST);
    state_d = state_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    init_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    id_d    = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d = INIT;
        gnt_d   = win;
        len_d   = win[1] ? req_len1 : req_len0;
        init_d  = 1'b1;
      end
      INIT: begin
        state_d = RUN;
        cnt_d   = '0;
        tmr_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_inc;
        tmr_d = char_rdy ? '0 : tmr_q + 1'b1;
        if (stop) begin
          state_d = REPORT;
          done_d  = 1'b1;
          err_d   = abort || cnt_inc < exp_c;
          id_d    = gnt_q[1];
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = gnt_q[1];
      end
    endcase
  end

  // ptr resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      tmr_q   <= '0;
      init_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      init_q  <= init_d;
      done_q  <= done_d;
      err_q   <= err_d;
      id_q    <= id_d;
    end
  end

  assign gnt      = gnt_q;
  assign init     = init_q;
  assign len_out  = len_q;
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign done_err = err_q;
  assign done_id  = id_q;
endmodule

// File: tb/tb_ai_cmp_sched.sv
// tb_ai_cmp_sched: table-driven plus directed multi-cycle checks of ai_cmp_sched with TIMEOUT=100
module tb_ai_cmp_sched;
  logic        clk = 1'b0;
  logic        rst, char_rdy, abort;
  logic [1:0]  req;
  logic [15:0] req_len0, req_len1;
  logic [1:0]  gnt;
  logic        init, busy, done, done_err, done_id;
  logic [15:0] len_out;
  logic [22:0] outs;
  int          checks = 0;
  int          errors = 0;
  int          early;
  int          k;

  typedef struct packed {
    logic        rst;
    logic [1:0]  req;
    logic [15:0] l0;
    logic [15:0] l1;
    logic        cr;
    logic        ab;
    logic [22:0] exp;
  } vec_t;
  vec_t tv [13];

  ai_cmp_sched #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .char_rdy(char_rdy), .abort(abort), .gnt(gnt), .init(init), .len_out(len_out),
    .busy(busy), .done(done), .done_err(done_err), .done_id(done_id)
  );

  always #5 clk = ~clk;
  assign outs = {gnt, init, busy, done, done_err, done_id, len_out};

  function automatic logic [22:0] e(input logic [1:0] g, input logic i, input logic b,
                                    input logic d, input logic er, input logic id, input logic [15:0] l);
    e = {g, i, b, d, er, id, l};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulses(input int n);
    char_rdy = 1'b1;
    repeat (n) begin
      step;
      if (done) early++;
    end
    char_rdy = 1'b0;
  endtask

  task automatic quiet(input int n);
    char_rdy = 1'b0;
    repeat (n) begin
      step;
      if (done) early++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b1, 2'b00, 16'd5, 16'd7, 1'b0, 1'b0, e(2'b00, 0, 0, 0, 0, 0, 16'd0)};
    tv[1]  = '{1'b0, 2'b01, 16'd5, 16'd7, 1'b0, 1'b0, e(2'b01, 1, 1, 0, 0, 0, 16'd5)};
    tv[2]  = '{1'b0, 2'b00, 16'd5, 16'd7, 1'b0, 1'b0, e(2'b01, 0, 1, 0, 0, 0, 16'd5)};
    tv[3]  = '{1'b0, 2'b00, 16'd5, 16'd7, 1'b0, 1'b1, e(2'b01, 0, 1, 1, 1, 0, 16'd5)};
    tv[4]  = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b00, 0, 0, 0, 0, 0, 16'd5)};
    tv[5]  = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b10, 1, 1, 0, 0, 0, 16'd1)};
    tv[6]  = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b1, 1'b0, e(2'b10, 0, 1, 0, 0, 0, 16'd1)};
    tv[7]  = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b10, 0, 1, 1, 0, 1, 16'd1)};
    tv[8]  = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b00, 0, 0, 0, 0, 0, 16'd1)};
    tv[9]  = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b01, 1, 1, 0, 0, 0, 16'd0)};
    tv[10] = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b01, 0, 1, 0, 0, 0, 16'd0)};
    tv[11] = '{1'b0, 2'b11, 16'd0, 16'd1, 1'b0, 1'b0, e(2'b01, 0, 1, 1, 0, 0, 16'd0)};
    tv[12] = '{1'b0, 2'b00, 16'd0, 16'd1, 1'b0, 1'b1, e(2'b00, 0, 0, 0, 0, 0, 16'd0)};
    rst = 1'b1; req = '0; req_len0 = '0; req_len1 = '0; char_rdy = 1'b0; abort = 1'b0;
    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst; req = tv[i].req; req_len0 = tv[i].l0; req_len1 = tv[i].l1;
      char_rdy = tv[i].cr; abort = tv[i].ab;
      step;
      chk($sformatf("vec%0d", i), 32'(outs), 32'(tv[i].exp));
    end
    char_rdy = 1'b0; abort = 1'b0;

    req = 2'b01; req_len0 = 16'd2;
    step;
    chk("c1_init", {gnt, init}, 3'b011);
    req = 2'b00;
    step;
    early = 0;
    pulses(511);
    chk("c1_early", early, 0);
    pulses(1);
    chk("c1_done", {done, done_err, done_id}, 3'b100);
    step;

    req = 2'b10; req_len1 = 16'd3;
    step;
    chk("c2_init", {gnt, init, len_out}, {3'b101, 16'd3});
    req = 2'b00;
    step;
    early = 0;
    pulses(600);
    chk("c2_early", early, 0);
    k = 0;
    while (!done && k < 200) begin
      step;
      k++;
    end
    chk("c2_lat", k, 100);
    chk("c2_done", {done, done_err, done_id}, 3'b111);
    step;

    req = 2'b01; req_len0 = 16'd3;
    step;
    step;
    req = 2'b00;
    early = 0;
    pulses(10);
    quiet(99);
    pulses(1);
    chk("c6_t99_early", early, 0);
    chk("c6_t99_busy", {busy, gnt}, 3'b101);
    pulses(1012);
    chk("c5_early", early, 0);
    char_rdy = 1'b1; abort = 1'b1;
    step;
    char_rdy = 1'b0; abort = 1'b0;
    chk("c5_done", {done, done_err, done_id}, 3'b110);
    step;

    req = 2'b10; req_len1 = 16'd2;
    step;
    step;
    req = 2'b00;
    pulses(5);
    rst = 1'b1;
    step;
    chk("c6_rst", 32'(outs), 32'd0);
    rst = 1'b0;
    early = 0;
    quiet(5);
    chk("c6_nodone", {early[7:0], busy}, 9'd0);
    req = 2'b11; req_len0 = 16'd4;
    step;
    chk("c6_tie", {gnt, len_out}, {2'b01, 16'd4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
